// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Dynamic branch predictor for the 5-stage MIPS pipeline. It is a direct-mapped
// table of 2-bit saturating counters, indexed by PC[INDEX_BITS+1:2].
//   - IF stage: combinational read with the fetch PC gives IF_PredTaken.
//   - IF->ID register: carries valid, table index and prediction into ID.
//   - ID stage: compares the resolved outcome with the carried prediction,
//     flags ID_Mispredict, and trains the counter when the branch leaves ID.
//
// Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
// Predict taken when the counter MSB is set.
//
// Optional feature macro: BRANCH_PREDICTOR_STATS_EN
//   When defined, BranchCount / MispredictCount statistics outputs are added.
//   When undefined, those counters and ports do not exist.
//
// Parameters:
//   INDEX_BITS       table index width (2^INDEX_BITS entries)
// Ports:
//   Clk              in   pipeline clock, rising-edge active
//   Reset            in   asynchronous active-high reset
//   IF_PC[31:0]      in   PC of the instruction being fetched
//   IF_Valid         in   fetch slot holds a real instruction
//   ID_Stall         in   ID stage held; IF->ID register keeps its value
//   ID_Flush         in   ID stage squashed; IF->ID register invalidated
//   ID_IsBranch      in   instruction in ID is a conditional branch
//   ID_Taken         in   resolved outcome for the ID instruction
//   IF_PredTaken     out  combinational prediction for IF_PC
//   ID_PredTaken     out  registered prediction carried with the ID instr
//   ID_Mispredict    out  ID branch resolved opposite to its prediction
//   BranchCount      out  (stats only) number of trained branches
//   MispredictCount  out  (stats only) number of trained mispredicted branches
// -----------------------------------------------------------------------------
module branch_predictor #(
   parameter int INDEX_BITS = 6
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] IF_PC,
   input  logic        IF_Valid,
   input  logic        ID_Stall,
   input  logic        ID_Flush,
   input  logic        ID_IsBranch,
   input  logic        ID_Taken,
   output logic        IF_PredTaken,
   output logic        ID_PredTaken,
`ifdef BRANCH_PREDICTOR_STATS_EN
   output logic        ID_Mispredict,
   output logic [31:0] BranchCount,
   output logic [31:0] MispredictCount
`else
   output logic        ID_Mispredict
`endif
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   localparam logic [1:0] CTR_STRONG_NT = 2'b00;
   localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
   localparam logic [1:0] CTR_STRONG_T  = 2'b11;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [1:0]            ctr_q [ENTRIES];

   logic                  id_valid_q, id_valid_d;
   logic [INDEX_BITS-1:0] id_index_q, id_index_d;
   logic                  id_pred_q,  id_pred_d;

   logic [INDEX_BITS-1:0] if_index;
   logic                  train;
   logic [1:0]            ctr_cur;
   logic [1:0]            ctr_d;

   // Only PC[INDEX_BITS+1:2] selects an entry; the remaining bits alias.
   logic                  unused_pc_bits;
   assign unused_pc_bits = ^{IF_PC[31:INDEX_BITS+2], IF_PC[1:0]};

   // ---------------------------------------------------------------------------
   // IF stage: combinational lookup. A same-cycle write to this entry is not
   // bypassed, so the IF read always sees the pre-update counter.
   // ---------------------------------------------------------------------------
   assign if_index     = IF_PC[INDEX_BITS+1:2];
   assign IF_PredTaken = ctr_q[if_index][1] & IF_Valid;

   // ---------------------------------------------------------------------------
   // IF->ID register next state. Flush wins over stall.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every comb output gets a default first so no path can leave it
      // unassigned, which would otherwise infer a latch.
      id_valid_d = id_valid_q;
      id_index_d = id_index_q;
      id_pred_d  = id_pred_q;
      if (ID_Flush) begin
         // Index is don't-care once invalid; holding it saves a mux input.
         id_valid_d = 1'b0;
         id_pred_d  = 1'b0;
      end else if (!ID_Stall) begin
         id_valid_d = IF_Valid;
         id_index_d = if_index;
         id_pred_d  = IF_PredTaken;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge values regardless of statement order.
         id_valid_q <= 1'b0;
         id_index_q <= '0;
         id_pred_q  <= 1'b0;
      end else begin
         id_valid_q <= id_valid_d;
         id_index_q <= id_index_d;
         id_pred_q  <= id_pred_d;
      end
   end

   // ---------------------------------------------------------------------------
   // ID stage: mispredict detection and training.
   // ---------------------------------------------------------------------------
   assign ID_PredTaken  = id_pred_q;
   assign ID_Mispredict = id_valid_q & ID_IsBranch & (ID_Taken != id_pred_q);

   // Train only on the edge where a valid branch actually leaves ID, so each
   // branch updates its counter exactly once.
   assign train   = id_valid_q & ID_IsBranch & ~ID_Stall & ~ID_Flush;
   assign ctr_cur = ctr_q[id_index_q];

   always_comb begin
      ctr_d = ctr_cur;
      if (ID_Taken) begin
         if (ctr_cur != CTR_STRONG_T) begin
            ctr_d = ctr_cur + 2'd1;
         end
      end else begin
         if (ctr_cur != CTR_STRONG_NT) begin
            ctr_d = ctr_cur - 2'd1;
         end
      end
   end

   // NOTE: the counter table is flop-based and must reset every entry to
   // weak-NT, so it cannot map onto a reset-less RAM macro.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_q[i] <= CTR_WEAK_NT;
         end
      end else if (train) begin
         ctr_q[id_index_q] <= ctr_d;
      end
   end

`ifdef BRANCH_PREDICTOR_STATS_EN
   // ---------------------------------------------------------------------------
   // Statistics: both counters advance on training edges and wrap at 2^32.
   // ---------------------------------------------------------------------------
   logic [31:0] branch_count_q, branch_count_d;
   logic [31:0] mispredict_count_q, mispredict_count_d;

   always_comb begin
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;
      if (train) begin
         branch_count_d = branch_count_q + 32'd1;
         if (ID_Mispredict) begin
            mispredict_count_d = mispredict_count_q + 32'd1;
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign BranchCount     = branch_count_q;
   assign MispredictCount = mispredict_count_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Self-checking bench for branch_predictor (INDEX_BITS = 6). A behavioural
// model keeps the counter table as plain integers 0..3 and the ID slot as a
// few variables; expectations come from that model or from constants.
// Build with +define+BRANCH_PREDICTOR_STATS_EN to also check the statistics.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

   localparam int IB = 6;
   localparam int N  = 1 << IB;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] IF_PC;
   logic        IF_Valid, ID_Stall, ID_Flush, ID_IsBranch, ID_Taken;
   logic        IF_PredTaken, ID_PredTaken, ID_Mispredict;
`ifdef BRANCH_PREDICTOR_STATS_EN
   logic [31:0] BranchCount, MispredictCount;
`endif

   branch_predictor #(.INDEX_BITS(IB)) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .IF_PC         (IF_PC),
      .IF_Valid      (IF_Valid),
      .ID_Stall      (ID_Stall),
      .ID_Flush      (ID_Flush),
      .ID_IsBranch   (ID_IsBranch),
      .ID_Taken      (ID_Taken),
      .IF_PredTaken  (IF_PredTaken),
      .ID_PredTaken  (ID_PredTaken),
`ifdef BRANCH_PREDICTOR_STATS_EN
      .ID_Mispredict (ID_Mispredict),
      .BranchCount   (BranchCount),
      .MispredictCount(MispredictCount)
`else
      .ID_Mispredict (ID_Mispredict)
`endif
   );

   always #5 Clk = ~Clk;

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   int   model_ctr [N];
   bit   m_valid;
   int   m_idx;
   bit   m_pred;
   int   br_cnt, mis_cnt;

   // Values sampled mid-cycle by step() and the model's view of that cycle.
   logic obs_if, obs_idp, obs_mis;
   logic exp_if, exp_idp, exp_mis;

   int   vecs  = 0;
   int   fails = 0;

   function automatic int pc_index(input logic [31:0] pc);
      return int'(pc >> 2) % N;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) model_ctr[i] = 1;
      m_valid = 0; m_idx = 0; m_pred = 0;
      br_cnt  = 0; mis_cnt = 0;
   endtask

   // Drive one cycle (called at posedge+1), sample outputs mid-cycle, advance
   // the model across the rising edge, and return at the next posedge+1.
   task automatic step(input logic [31:0] pc, input logic v, input logic st,
                       input logic fl, input logic br, input logic tk);
      int idx;
      IF_PC = pc; IF_Valid = v; ID_Stall = st; ID_Flush = fl;
      ID_IsBranch = br; ID_Taken = tk;
      #3;
      idx     = pc_index(pc);
      exp_if  = v && (model_ctr[idx] >= 2);
      exp_idp = m_pred;
      exp_mis = m_valid && br && (tk != m_pred);
      obs_if  = IF_PredTaken;
      obs_idp = ID_PredTaken;
      obs_mis = ID_Mispredict;
      @(posedge Clk);
      if (m_valid && br && !st && !fl) begin
         model_ctr[m_idx] = tk ? ((model_ctr[m_idx] < 3) ? model_ctr[m_idx] + 1 : 3)
                               : ((model_ctr[m_idx] > 0) ? model_ctr[m_idx] - 1 : 0);
         br_cnt++;
         if (exp_mis) mis_cnt++;
      end
      if (fl) begin
         m_valid = 0; m_pred = 0;
      end else if (!st) begin
         m_valid = v; m_idx = idx; m_pred = exp_if;
      end
      #1;
   endtask

   task automatic apply_reset();
      Reset = 1'b1;
      IF_PC = 32'h0; IF_Valid = 0; ID_Stall = 0; ID_Flush = 0;
      ID_IsBranch = 0; ID_Taken = 0;
      model_reset();
      @(posedge Clk); #1;
      Reset = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      Reset = 1'b1;
      model_reset();
      IF_PC = 32'h40; IF_Valid = 1; ID_Stall = 0; ID_Flush = 0;
      ID_IsBranch = 1; ID_Taken = 1;
      #2;
      vecs++;
      if ({IF_PredTaken, ID_PredTaken, ID_Mispredict} !== 3'b000) begin
         fails++;
         $display("FAIL reset_outputs: got if/id/mis=%b%b%b want 000",
                  IF_PredTaken, ID_PredTaken, ID_Mispredict);
      end
`ifdef BRANCH_PREDICTOR_STATS_EN
      vecs++;
      if (BranchCount !== 32'd0 || MispredictCount !== 32'd0) begin
         fails++;
         $display("FAIL reset_stats: got %0d/%0d want 0/0", BranchCount, MispredictCount);
      end
`endif
      @(posedge Clk); #1;
      Reset = 1'b0;
      // Every entry must read as weak-NT straight after reset.
      for (int i = 0; i < N; i++) begin
         step(32'(i * 4), 1, 0, 0, 0, 0);
         vecs++;
         if (obs_if !== 1'b0) begin
            fails++;
            $display("FAIL reset_entry_%0d: got pred %b want 0", i, obs_if);
         end
      end
   endtask

   task automatic test_train_saturate();
      apply_reset();
      step(32'h40, 1, 0, 0, 0, 0);
      vecs++;
      if (obs_if !== 1'b0) begin
         fails++; $display("FAIL first_fetch: got %b want 0", obs_if);
      end
      step(32'h0, 0, 0, 0, 1, 1);
      vecs++;
      if (obs_mis !== 1'b1) begin
         fails++; $display("FAIL first_mispredict: got %b want 1", obs_mis);
      end
      // Three more taken outcomes: 10 -> 11 -> 11 -> 11.
      for (int k = 0; k < 3; k++) begin
         step(32'h40, 1, 0, 0, 0, 0);
         step(32'h0, 0, 0, 0, 1, 1);
         vecs++;
         if ({obs_idp, obs_mis} !== {exp_idp, exp_mis}) begin
            fails++;
            $display("FAIL sat_taken_%0d: got idp/mis=%b%b want %b%b", k,
                     obs_idp, obs_mis, exp_idp, exp_mis);
         end
      end
      step(32'h40, 1, 0, 0, 0, 0);
      vecs++;
      if (obs_if !== 1'b1) begin
         fails++; $display("FAIL saturated_pred: got %b want 1", obs_if);
      end
      // Two not-taken outcomes: 11 -> 10 -> 01. The first consumes the fetch
      // issued above.
      step(32'h40, 1, 0, 0, 1, 0);
      step(32'h0, 0, 0, 0, 1, 0);
      step(32'h40, 1, 0, 0, 0, 0);
      vecs++;
      if (obs_if !== 1'b0) begin
         fails++; $display("FAIL after_two_nt: got %b want 0", obs_if);
      end
   endtask

   task automatic test_alias();
      apply_reset();
      for (int k = 0; k < 2; k++) begin
         step(32'h40, 1, 0, 0, 0, 0);
         step(32'h0, 0, 0, 0, 1, 1);
      end
      step(32'h140, 1, 0, 0, 0, 0);
      vecs++;
      if (obs_if !== 1'b1) begin
         fails++; $display("FAIL alias_0x140: got %b want 1", obs_if);
      end
   endtask

   task automatic test_stall();
      apply_reset();
      // Bring entry 16 to 10 so the stalled branch carries prediction 1.
      step(32'h40, 1, 0, 0, 0, 0);
      step(32'h0, 0, 0, 0, 1, 1);
      step(32'h40, 1, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         step(32'h40, 1, 1, 0, 1, 1);
         vecs++;
         if ({obs_if, obs_idp} !== 2'b11) begin
            fails++;
            $display("FAIL stall_hold_%0d: got if/idp=%b%b want 11", k, obs_if, obs_idp);
         end
      end
      // Release: exactly one update (10 -> 11), then one not-taken -> 10.
      step(32'h0, 0, 0, 0, 1, 1);
      step(32'h40, 1, 0, 0, 0, 0);
      step(32'h0, 0, 0, 0, 1, 0);
      step(32'h40, 1, 0, 0, 0, 0);
      vecs++;
      if (obs_if !== 1'b1) begin
         fails++; $display("FAIL stall_single_update: got %b want 1", obs_if);
      end
   endtask

   task automatic test_flush_and_bypass();
      apply_reset();
      step(32'h40, 1, 0, 0, 0, 0);
      step(32'h0, 0, 1, 1, 1, 1);            // flush + stall with branch in ID
      step(32'h40, 1, 0, 0, 1, 1);           // ID now invalid
      vecs++;
      if ({obs_idp, obs_mis} !== 2'b00) begin
         fails++; $display("FAIL flush_invalidates: got idp/mis=%b%b want 00", obs_idp, obs_mis);
      end
      // Entry 16 still 01: resolve taken while fetching the same index.
      step(32'h40, 1, 0, 0, 1, 1);
      vecs++;
      if (obs_if !== 1'b0) begin
         fails++; $display("FAIL bypass_old_value: got %b want 0", obs_if);
      end
      step(32'h40, 1, 0, 0, 0, 0);
      vecs++;
      if (obs_if !== 1'b1) begin
         fails++; $display("FAIL bypass_new_value: got %b want 1", obs_if);
      end
   endtask

   task automatic test_stats();
      // Five branches at distinct entries, outcomes T,N,N,T,N, all predicted
      // not-taken -> 2 mispredicts.
      logic [4:0] outcome;
      outcome = 5'b01001;
      apply_reset();
      step(32'h100, 1, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         step(32'(32'h104 + k * 4), (k < 4), 0, 0, 1, outcome[k]);
      end
`ifdef BRANCH_PREDICTOR_STATS_EN
      vecs++;
      if (BranchCount !== 32'd5 || MispredictCount !== 32'd2) begin
         fails++;
         $display("FAIL stats_5_2: got %0d/%0d want 5/2", BranchCount, MispredictCount);
      end
`endif
      vecs++;
      if (br_cnt != 5 || mis_cnt != 2) begin
         fails++; $display("FAIL stats_model_5_2: got %0d/%0d want 5/2", br_cnt, mis_cnt);
      end
   endtask

   task automatic test_random();
      logic [31:0] pc;
      logic v, st, fl, br, tk;
      apply_reset();
      for (int n = 0; n < 600; n++) begin
         // Few indices plus random upper bits to stress aliasing and saturation.
         pc = {$urandom_range(0, 255) << 8} | 32'($urandom_range(0, 7) << 2);
         v  = ($urandom_range(0, 9) < 8);
         st = ($urandom_range(0, 9) < 2);
         fl = ($urandom_range(0, 9) < 1);
         br = ($urandom_range(0, 9) < 7);
         tk = ($urandom_range(0, 9) < 6);
         step(pc, v, st, fl, br, tk);
         vecs++;
         if ({obs_if, obs_idp, obs_mis} !== {exp_if, exp_idp, exp_mis}) begin
            fails++;
            $display("FAIL random_%0d pc=%h: got if/idp/mis=%b%b%b want %b%b%b", n, pc,
                     obs_if, obs_idp, obs_mis, exp_if, exp_idp, exp_mis);
         end
`ifdef BRANCH_PREDICTOR_STATS_EN
         vecs++;
         if (BranchCount !== 32'(br_cnt) || MispredictCount !== 32'(mis_cnt)) begin
            fails++;
            $display("FAIL random_stats_%0d: got %0d/%0d want %0d/%0d", n,
                     BranchCount, MispredictCount, br_cnt, mis_cnt);
         end
`endif
      end
   endtask

   task automatic test_reset_midstream();
      // Saturate entry 16 taken with a predicted-taken branch left in ID.
      for (int k = 0; k < 3; k++) begin
         step(32'h40, 1, 0, 0, 0, 0);
         step(32'h0, 0, 0, 0, 1, 1);
      end
      step(32'h40, 1, 0, 0, 0, 0);
      IF_PC = 32'h40; IF_Valid = 1; ID_IsBranch = 1; ID_Taken = 0;
      #2;
      Reset = 1'b1;
      #1;
      vecs++;
      if ({IF_PredTaken, ID_PredTaken, ID_Mispredict} !== 3'b000) begin
         fails++;
         $display("FAIL midstream_reset: got if/idp/mis=%b%b%b want 000",
                  IF_PredTaken, ID_PredTaken, ID_Mispredict);
      end
`ifdef BRANCH_PREDICTOR_STATS_EN
      vecs++;
      if (BranchCount !== 32'd0 || MispredictCount !== 32'd0) begin
         fails++;
         $display("FAIL midstream_stats: got %0d/%0d want 0/0", BranchCount, MispredictCount);
      end
`endif
      model_reset();
      @(posedge Clk); #1;
      Reset = 1'b0;
      step(32'h40, 1, 0, 0, 0, 0);
      vecs++;
      if (obs_if !== 1'b0) begin
         fails++; $display("FAIL post_reset_entry: got %b want 0", obs_if);
      end
   endtask

   initial begin
      test_reset();
      test_train_saturate();
      test_alias();
      test_stall();
      test_flush_and_bypass();
      test_stats();
      test_random();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
